// File: rtl/avmm_cmd_pkg.sv
// Shared types and constants for the Avalon-MM command master.
package avmm_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/avmm_cmd_master.sv
// Single-beat Avalon-MM master: one command in, one slave access, one response out.
module avmm_cmd_master
  import avmm_cmd_pkg::*;
#(
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic              av_read_n,
  output logic [ADDR_W-1:0] av_address,
  output logic [DATA_W-1:0] av_writedata,
  input  logic [DATA_W-1:0] av_readdata,
  output logic              busy
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  op;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Strobes reset asynchronously so an aborted access releases the bus at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      op            <= OP_READ;
      av_chipselect <= 1'b0;
      av_write_n    <= 1'b1;
      av_read_n     <= 1'b1;
      av_address    <= '0;
      av_writedata  <= '0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_readdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op            <= cmd_write;
            av_address    <= cmd_address;
            av_writedata  <= cmd_writedata;
            av_chipselect <= 1'b1;
            av_write_n    <= ~cmd_write;
            av_read_n     <= cmd_write;
            wait_cnt      <= WAIT_INIT;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          // Counter at zero marks the last access cycle; readdata is valid now.
          if (wait_cnt == '0) begin
            rsp_readdata  <= (op == OP_WRITE) ? '0 : av_readdata;
            rsp_write     <= (op == OP_WRITE);
            rsp_valid     <= 1'b1;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_read_n     <= 1'b1;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Bench for avmm_cmd_master: two instances (0 and 3 wait states), each on a register-file slave.
module tb_avmm_cmd_master;

  logic        clk;
  logic        reset_n       [2];
  logic        cmd_valid     [2];
  logic        cmd_ready     [2];
  logic        cmd_write     [2];
  logic [1:0]  cmd_address   [2];
  logic [31:0] cmd_writedata [2];
  logic        rsp_valid     [2];
  logic        rsp_ready     [2];
  logic        rsp_write     [2];
  logic [31:0] rsp_readdata  [2];
  logic        av_chipselect [2];
  logic        av_write_n    [2];
  logic        av_read_n     [2];
  logic [1:0]  av_address    [2];
  logic [31:0] av_writedata  [2];
  logic [31:0] av_readdata   [2];
  logic        busy          [2];

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] model_mem [2][4];
  bit          exp_wr    [2];
  logic [31:0] exp_rd    [2];
  logic [1:0]  exp_addr  [2];
  logic [31:0] exp_data  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : 3;
    logic [31:0] mem [4];
    logic [3:0]  cs_cnt;

    avmm_cmd_master #(.ADDR_W(2), .DATA_W(32), .WAIT_STATES(WS)) u_dut (
      .clk(clk), .reset_n(reset_n[g]),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write[g]),
      .cmd_address(cmd_address[g]), .cmd_writedata(cmd_writedata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_write(rsp_write[g]),
      .rsp_readdata(rsp_readdata[g]),
      .av_chipselect(av_chipselect[g]), .av_write_n(av_write_n[g]), .av_read_n(av_read_n[g]),
      .av_address(av_address[g]), .av_writedata(av_writedata[g]), .av_readdata(av_readdata[g]),
      .busy(busy[g])
    );

    initial begin
      for (int i = 0; i < 4; i++) mem[i] = '0;
      cs_cnt = '0;
    end

    // Slow slave: read data is only valid on the final access cycle.
    always @(posedge clk) begin
      cs_cnt <= av_chipselect[g] ? cs_cnt + 4'd1 : 4'd0;
      if (av_chipselect[g] && !av_write_n[g]) mem[av_address[g]] <= av_writedata[g];
    end
    assign av_readdata[g] = (av_chipselect[g] && cs_cnt == 4'(WS)) ? mem[av_address[g]] : 32'hBAD0_BAD0;
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic set_expect(input int d, input bit wr, input logic [1:0] addr, input logic [31:0] data);
    exp_wr[d]   = wr;
    exp_addr[d] = addr;
    exp_data[d] = data;
    exp_rd[d]   = wr ? 32'h0 : model_mem[d][addr];
    if (wr) model_mem[d][addr] = data;
  endtask

  task automatic start_cmd(input int d, input bit wr, input logic [1:0] addr, input logic [31:0] data);
    for (int i = 0; i < 50 && !cmd_ready[d]; i++) begin
      @(posedge clk); #1;
    end
    chk1("cmd_ready_wait", cmd_ready[d], 1'b1);
    cmd_write[d]     = wr;
    cmd_address[d]   = addr;
    cmd_writedata[d] = data;
    cmd_valid[d]     = 1'b1;
    @(posedge clk); #1;
    cmd_valid[d] = 1'b0;
  endtask

  task automatic access_phase(input int d);
    int n = 0;
    while (av_chipselect[d] && n < 40) begin
      chk1("acc_write_n", av_write_n[d], !exp_wr[d]);
      chk1("acc_read_n", av_read_n[d], exp_wr[d]);
      chk32("acc_address", {30'b0, av_address[d]}, {30'b0, exp_addr[d]});
      if (exp_wr[d]) chk32("acc_writedata", av_writedata[d], exp_data[d]);
      chk1("acc_no_rsp", rsp_valid[d], 1'b0);
      n++;
      @(posedge clk); #1;
    end
    chk32("access_len", n, 32'(1 + ws_of(d)));
    chk1("rsp_valid_rise", rsp_valid[d], 1'b1);
  endtask

  task automatic resp_phase(input int d, input int delay);
    chk1("rsp_write", rsp_write[d], exp_wr[d]);
    chk32("rsp_readdata", rsp_readdata[d], exp_rd[d]);
    rsp_ready[d] = 1'b0;
    repeat (delay) begin
      @(posedge clk); #1;
      chk1("hold_valid", rsp_valid[d], 1'b1);
      chk1("hold_write", rsp_write[d], exp_wr[d]);
      chk32("hold_readdata", rsp_readdata[d], exp_rd[d]);
      chk1("hold_cmd_ready", cmd_ready[d], 1'b0);
      chk1("hold_no_cs", av_chipselect[d], 1'b0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk1("done_rsp_valid", rsp_valid[d], 1'b0);
    chk1("done_cmd_ready", cmd_ready[d], 1'b1);
    chk1("done_busy", busy[d], 1'b0);
  endtask

  task automatic run_cmd(input int d, input bit wr, input logic [1:0] addr, input logic [31:0] data,
                         input int delay);
    set_expect(d, wr, addr, data);
    start_cmd(d, wr, addr, data);
    access_phase(d);
    resp_phase(d, delay);
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;
    int          delay;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [31:0] rd;
  } exp_t;

  initial begin
    vec_t tbl [8];
    exp_t q [$];
    exp_t e;
    int   n_acc, n_rsp, last, cyc, cnt;
    bit   acc;

    tbl[0] = '{1'b1, 2'd0, 32'h0000_0003, 0, 32'h0};
    tbl[1] = '{1'b0, 2'd0, 32'h0,         0, 32'h0000_0003};
    tbl[2] = '{1'b0, 2'd1, 32'h0,         1, 32'h0};
    tbl[3] = '{1'b1, 2'd3, 32'hDEAD_BEEF, 2, 32'h0};
    tbl[4] = '{1'b0, 2'd3, 32'h0,         0, 32'hDEAD_BEEF};
    tbl[5] = '{1'b1, 2'd1, 32'hA5A5_5A5A, 0, 32'h0};
    tbl[6] = '{1'b0, 2'd1, 32'h0,         3, 32'hA5A5_5A5A};
    tbl[7] = '{1'b0, 2'd0, 32'h0,         0, 32'h0000_0003};

    for (int d = 0; d < 2; d++) begin
      reset_n[d] = 1'b0; cmd_valid[d] = 1'b0; cmd_write[d] = 1'b0;
      cmd_address[d] = '0; cmd_writedata[d] = '0; rsp_ready[d] = 1'b0;
      for (int a = 0; a < 4; a++) model_mem[d][a] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk1("rst_cs", av_chipselect[d], 1'b0);
      chk1("rst_write_n", av_write_n[d], 1'b1);
      chk1("rst_read_n", av_read_n[d], 1'b1);
      chk32("rst_address", {30'b0, av_address[d]}, 32'h0);
      chk32("rst_writedata", av_writedata[d], 32'h0);
      chk1("rst_rsp_valid", rsp_valid[d], 1'b0);
      chk1("rst_rsp_write", rsp_write[d], 1'b0);
      chk32("rst_rsp_readdata", rsp_readdata[d], 32'h0);
      chk1("rst_busy", busy[d], 1'b0);
      chk1("rst_cmd_ready", cmd_ready[d], 1'b1);
      reset_n[d] = 1'b1;
    end
    @(posedge clk); #1;

    // Table-driven write/read sequence on the zero-wait-state instance.
    for (int i = 0; i < 8; i++) begin
      set_expect(0, tbl[i].wr, tbl[i].addr, tbl[i].data);
      exp_rd[0] = tbl[i].exp_rd;
      start_cmd(0, tbl[i].wr, tbl[i].addr, tbl[i].data);
      access_phase(0);
      resp_phase(0, tbl[i].delay);
      if (i == 0) chk32("pio_out_port", {30'b0, g_dut[0].mem[0][1:0]}, 32'h3);
    end

    // Three wait states: four strobe cycles, data taken on the last one.
    run_cmd(1, 1'b1, 2'd1, 32'h0BAD_F00D, 0);
    run_cmd(1, 1'b0, 2'd1, 32'h0, 0);
    chk32("ws3_readdata", rsp_readdata[1], 32'h0BAD_F00D);

    // Long backpressure with a second command waiting.
    set_expect(0, 1'b0, 2'd3, 32'h0);
    start_cmd(0, 1'b0, 2'd3, 32'h0);
    access_phase(0);
    cmd_write[0] = 1'b1; cmd_address[0] = 2'd2; cmd_writedata[0] = 32'h5A5A_0F0F; cmd_valid[0] = 1'b1;
    resp_phase(0, 10);
    chk1("t4_no_overlap", av_chipselect[0], 1'b0);
    set_expect(0, 1'b1, 2'd2, 32'h5A5A_0F0F);
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    chk1("t4_accept_next", av_chipselect[0], 1'b1);
    access_phase(0);
    resp_phase(0, 0);

    // Back-to-back traffic with both handshakes tied high.
    n_acc = 0; n_rsp = 0; last = -1; cyc = 0;
    cmd_write[0] = 1'(($urandom_range(0, 1))); cmd_address[0] = 2'($urandom_range(0, 3));
    cmd_writedata[0] = $urandom; cmd_valid[0] = 1'b1; rsp_ready[0] = 1'b1;
    while ((n_acc < 20 || q.size() > 0) && cyc < 500) begin
      acc = cmd_valid[0] && cmd_ready[0];
      if (acc) begin
        e.wr = cmd_write[0];
        e.rd = cmd_write[0] ? 32'h0 : model_mem[0][cmd_address[0]];
        if (cmd_write[0]) model_mem[0][cmd_address[0]] = cmd_writedata[0];
        q.push_back(e);
        if (last >= 0) chk32("b2b_spacing", cyc - last, 32'd3);
        last = cyc;
        n_acc++;
      end
      if (rsp_valid[0] && rsp_ready[0]) begin
        n_rsp++;
        if (q.size() == 0) begin
          chk1("b2b_extra_rsp", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk1("b2b_rsp_write", rsp_write[0], e.wr);
          chk32("b2b_rsp_readdata", rsp_readdata[0], e.rd);
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (n_acc == 20) cmd_valid[0] = 1'b0;
        else begin
          cmd_write[0] = 1'($urandom_range(0, 1)); cmd_address[0] = 2'($urandom_range(0, 3));
          cmd_writedata[0] = $urandom;
        end
      end
    end
    rsp_ready[0] = 1'b0;
    chk1("b2b_timeout", (cyc < 500), 1'b1);
    chk32("b2b_rsp_count", n_rsp, 32'(n_acc));

    // Reset during a write access discards it entirely.
    start_cmd(1, 1'b1, 2'd2, 32'h1234_5678);
    chk1("t6_cs_before", av_chipselect[1], 1'b1);
    chk1("t6_wn_before", av_write_n[1], 1'b0);
    #2 reset_n[1] = 1'b0;
    #1;
    chk1("t6_cs_async", av_chipselect[1], 1'b0);
    chk1("t6_wn_async", av_write_n[1], 1'b1);
    chk1("t6_rsp_valid", rsp_valid[1], 1'b0);
    chk1("t6_cmd_ready", cmd_ready[1], 1'b1);
    @(posedge clk); #1;
    reset_n[1] = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid[1] || av_chipselect[1]) cnt++;
    end
    chk32("t6_no_rsp_after", cnt, 32'h0);
    run_cmd(1, 1'b0, 2'd2, 32'h0, 0);
    run_cmd(1, 1'b1, 2'd2, 32'h7777_1111, 1);
    run_cmd(1, 1'b0, 2'd2, 32'h0, 0);

    // Random traffic against the register-file model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 25; i++) begin
        run_cmd(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                int'($urandom_range(0, 3)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
